mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF stage) and data access (MEM stage: lw/sw per the decoder's MemWrite/ResultSrc) in the 5-stage pipelined RV32I core.
- Holds one outstanding memory transaction at a time, with data priority.
- Drives stall_if/stall_mem into the hazard unit and returns fetched instruction and load data.

Parameters:
- XLEN, 32, data width.
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- adv  in  1  pipeline advances this cycle (no global stall).
- if_req  in  1  fetch wanted at if_addr.
- if_addr  in  AW  PCF.
- if_flush  in  1  branch/jump redirect; discard current fetch.
- if_rdata  out  XLEN  fetched instruction.
- if_valid  out  1  instruction available for current PCF.
- dm_req  in  1  load or store in MEM stage.
- dm_we  in  1  store (MemWrite).
- dm_addr  in  AW  ALUResultM.
- dm_wdata  in  XLEN  WriteDataM.
- dm_rdata  out  XLEN  load data.
- dm_valid  out  1  data access complete for current MEM instruction.
- stall_if  out  1  if_req & ~if_valid.
- stall_mem  out  1  dm_req & ~dm_valid.
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  write enable.
- mem_addr  out  AW  address.
- mem_wdata  out  XLEN  write data.
- mem_gnt  in  1  memory accepted request.
- mem_rvalid  in  1  response/ack, with mem_rdata.
- mem_rdata  in  XLEN  read data.

Behaviour:
- FSM states: IDLE, D_REQ, D_RSP, I_REQ, I_RSP.
- Reset: state IDLE; mem_req, mem_we, if_valid, dm_valid = 0; all data/addr registers = 0; done/drop flags = 0.
- IDLE, data first:
  - dm_req & ~dm_done → latch dm_we/addr/wdata, go D_REQ.
  - else if_req & ~if_done → latch if_addr, go I_REQ.
  - Simultaneous dm_req and if_req: data always wins.
- D_REQ/I_REQ:
  - mem_req=1; mem_we/addr/wdata come from the latched registers and stay stable until mem_gnt.
  - On mem_gnt go to the matching *_RSP state.
  - Minimum: request issues 1 cycle after IDLE; with gnt and rvalid each 1 cycle later, completion takes 3 cycles.
- D_RSP:
  - On mem_rvalid: capture mem_rdata (don't-care for stores), set dm_done, go IDLE.
  - Writes also wait for mem_rvalid.
- I_RSP:
  - On mem_rvalid: capture mem_rdata into if_rdata, set if_done unless drop is set, clear drop, go IDLE.
- dm_valid = dm_done; if_valid = if_done. Both are registered and held until adv=1.
- Done-flag clearing on adv=1:
  - dm_done and if_done clear, so the next instruction re-requests.
  - A completion and adv in the same cycle: completion wins (flag set). Impossible under correct hazard wiring; assert in simulation.
- if_flush:
  - In I_REQ or I_RSP: set drop. The transaction still completes on the memory side, but its response is discarded (no if_valid).
  - In any other state: clears if_done.
  - Never affects a data transaction.
- Writes are never dropped or duplicated: one store = exactly one mem_we transaction.
- mem_gnt/mem_rvalid outside the expected state are ignored.
- Reset asserted mid-transaction returns to IDLE immediately; the memory model must also be reset.

Optional Feature:
- ARB_PERF_CNT_EN defined: adds outputs perf_if_stall[31:0], perf_mem_stall[31:0] and perf_conflict[31:0].
  - Each saturates at all-ones and resets to 0.
  - They increment on stall_if, on stall_mem, and on cycles in IDLE with both requests pending.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package (riscv_pkg): FSM state encoding (arb_state_t), XLEN/AW defaults, opcode constants (OP_LOAD=0000011, OP_STORE=0100011).
- One natural sub-module: arb_perf_counter, a saturating counter instantiated 3x under ARB_PERF_CNT_EN.

Test Plan:
- Fetch only: if_req=1, addr=0x10; gnt and rvalid 1 cycle each, rdata=0x00500093 → if_valid=1 at cycle 3; if_rdata=0x00500093; stall_if low from then until adv.
- Conflict: if_req and dm_req (lw, 0x100) both rise in IDLE → first mem_req has addr 0x100, mem_we=0; fetch issues only after the data rvalid.
- Store: dm_we=1, addr 0x20, wdata 0xDEADBEEF, gnt delayed 4 cycles → mem_req held with stable addr/data for all 5 cycles; exactly one write; dm_valid after rvalid.
- Flush: if_flush during I_RSP → response discarded, if_valid stays 0, new if_addr fetched next.
- Hold: completion with adv=0 for 3 cycles → if_valid/dm_valid stay high and no re-request; adv=1 clears them.
- Reset: rst low in D_REQ → mem_req drops asynchronously to 0 and the FSM returns to IDLE; after release, pending requests are reissued.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I core: arbiter FSM encoding, width defaults
// and the load/store opcodes the decoder matches on.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_REQ = 3'd1,
    D_RSP = 3'd2,
    I_REQ = 3'd3,
    I_RSP = 3'd4
  } arb_state_t;

endpackage

// File: rtl/arb_perf_counter.sv
// Saturating event counter: counts cycles with i_inc high and sticks at all-ones.
module arb_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF fetch and MEM load/store, one
// transaction in flight, data first. ARB_PERF_CNT_EN adds stall/conflict counters.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_if_stall,
  output logic [31:0]     perf_mem_stall,
  output logic [31:0]     perf_conflict
`endif
);

  arb_state_t      r_state, w_state_nxt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_if_rdata, r_dm_rdata;
  logic            r_if_done, r_dm_done, r_drop;

  logic w_latch_d, w_latch_i, w_dm_cmpl, w_if_rsp, w_if_cmpl;
  logic w_in_fetch, w_flush_fetch;

  assign w_in_fetch    = (r_state == I_REQ) || (r_state == I_RSP);
  assign w_flush_fetch = if_flush && w_in_fetch;
  // A flush landing in the same cycle as the fetch response also discards it.
  assign w_if_cmpl     = w_if_rsp && !(r_drop || w_flush_fetch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch_d   = 1'b0;
    w_latch_i   = 1'b0;
    w_dm_cmpl   = 1'b0;
    w_if_rsp    = 1'b0;
    case (r_state)
      IDLE: begin
        if (dm_req && !r_dm_done) begin
          w_latch_d   = 1'b1;
          w_state_nxt = D_REQ;
        end else if (if_req && !r_if_done) begin
          w_latch_i   = 1'b1;
          w_state_nxt = I_REQ;
        end
      end
      D_REQ: if (mem_gnt) w_state_nxt = D_RSP;
      D_RSP: begin
        if (mem_rvalid) begin
          w_dm_cmpl   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      I_REQ: if (mem_gnt) w_state_nxt = I_RSP;
      I_RSP: begin
        if (mem_rvalid) begin
          w_if_rsp    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_done  <= 1'b0;
      r_dm_done  <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (w_latch_d) begin
        r_we    <= dm_we;
        r_addr  <= dm_addr;
        r_wdata <= dm_wdata;
      end else if (w_latch_i) begin
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_wdata <= '0;
      end
      if (w_dm_cmpl) r_dm_rdata <= mem_rdata;
      if (w_if_rsp)  r_if_rdata <= mem_rdata;

      // Completion beats adv so a finished access is never lost.
      if (w_dm_cmpl)  r_dm_done <= 1'b1;
      else if (adv)   r_dm_done <= 1'b0;

      if (w_if_cmpl)                       r_if_done <= 1'b1;
      else if (adv || (if_flush && !w_in_fetch)) r_if_done <= 1'b0;

      if (w_if_rsp)           r_drop <= 1'b0;
      else if (w_flush_fetch) r_drop <= 1'b1;
    end
  end

  assign mem_req   = (r_state == D_REQ) || (r_state == I_REQ);
  assign mem_we    = (r_state == D_REQ) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_valid  = r_if_done;
  assign dm_valid  = r_dm_done;
  assign stall_if  = if_req && !r_if_done;
  assign stall_mem = dm_req && !r_dm_done;

  a_no_adv_on_cmpl: assert property (@(posedge clk) disable iff (!rst)
    !(adv && (w_dm_cmpl || w_if_cmpl)));

`ifdef ARB_PERF_CNT_EN
  logic w_conflict;
  assign w_conflict = (r_state == IDLE) && dm_req && !r_dm_done && if_req && !r_if_done;

  arb_perf_counter #(.W(32)) u_perf_if (
    .clk(clk), .rst(rst), .i_inc(stall_if), .o_cnt(perf_if_stall)
  );
  arb_perf_counter #(.W(32)) u_perf_mem (
    .clk(clk), .rst(rst), .i_inc(stall_mem), .o_cnt(perf_mem_stall)
  );
  arb_perf_counter #(.W(32)) u_perf_conf (
    .clk(clk), .rst(rst), .i_inc(w_conflict), .o_cnt(perf_conflict)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, adv, if_req, if_flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, stall_if, stall_mem, mem_req, mem_we;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        slave_auto;
  logic        t_gnt, t_rvalid;
  logic [31:0] t_rdata;
  logic        s_gnt, s_rvalid, s_pend;
  logic [31:0] s_rdata, s_data;
  int          s_wait;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int          n_checks = 0, n_errs = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa, last_wd;

  assign mem_gnt    = slave_auto ? s_gnt    : t_gnt;
  assign mem_rvalid = slave_auto ? s_rvalid : t_rvalid;
  assign mem_rdata  = slave_auto ? s_rdata  : t_rdata;

  mem_port_arbiter #(.XLEN(32), .AW(32)) dut (
    .clk(clk), .rst(rst), .adv(adv),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Random-latency memory: grant after 0..3 cycles, respond 1..3 cycles after grant.
  always @(posedge clk) begin
    #2;
    if (!rst || !slave_auto) begin
      s_gnt = 1'b0; s_rvalid = 1'b0; s_pend = 1'b0; s_wait = 0; s_rdata = '0;
    end else begin
      s_gnt = 1'b0; s_rvalid = 1'b0;
      if (s_pend) begin
        if (s_wait == 0) begin
          s_rvalid = 1'b1; s_rdata = s_data; s_pend = 1'b0;
        end else s_wait--;
      end else if (mem_req) begin
        if (s_wait == 0) begin
          s_gnt = 1'b1;
          if (mem_we) smem[mem_addr] = mem_wdata;
          else s_data = smem.exists(mem_addr) ? smem[mem_addr] : dflt(mem_addr);
          s_pend = 1'b1;
          s_wait = $urandom_range(0, 2);
        end else s_wait--;
      end else s_wait = $urandom_range(0, 3);
    end
  end

  always @(negedge clk) begin
    if (rst && mem_req && mem_we && mem_gnt) begin
      wr_cnt++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
  end

  typedef struct packed {
    logic ifr; logic [31:0] ifa; logic dmr; logic dmw; logic [31:0] dma;
    logic adv; logic gnt; logic rv; logic [31:0] rd;
    logic e_req; logic e_we; logic [31:0] e_addr; logic e_ifv; logic e_dmv;
    logic e_sif; logic e_smem; logic c_ird; logic [31:0] e_ird; logic c_drd; logic [31:0] e_drd;
  } vec_t;

  vec_t tv [20];

  task automatic do_reset();
    rst = 1'b0; adv = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic cyc_drive(input logic g, input logic rv, input logic [31:0] rd);
    @(posedge clk); #1;
    t_gnt = g; t_rvalid = rv; t_rdata = rd;
  endtask

  logic [31:0] pc, dma, wd;
  int          kind, flush_at, w0;
  bit          done;
  logic        p_req, p_we, p_pend, p_dmw;
  logic [31:0] p_addr, p_wd, p_dma;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    slave_auto = 1'b0;
    //        ifr  ifa       dmr  dmw  dma        adv  gnt  rv   rd             req  we   addr       ifv  dmv  sif  smem cird ird            cdrd drd
    tv[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h10,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[3]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 32'h0};
    tv[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 32'h0};
    tv[5]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 32'h0};
    tv[6]  = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[7]  = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h14,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[8]  = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h14,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[9]  = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[10] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0};
    tv[11] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[12] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[13] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[14] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hCAFE0001};
    tv[15] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h18,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[16] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[17] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 32'hCAFE0001};
    tv[18] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tv[19] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_dm_valid", dm_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);

    // Fetch-only, hold, conflict and stray-response vectors
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if_req = tv[i].ifr; if_addr = tv[i].ifa; dm_req = tv[i].dmr; dm_we = tv[i].dmw;
      dm_addr = tv[i].dma; dm_wdata = '0; adv = tv[i].adv;
      t_gnt = tv[i].gnt; t_rvalid = tv[i].rv; t_rdata = tv[i].rd;
      @(negedge clk);
      chk($sformatf("tv%0d_mem_req", i), mem_req, tv[i].e_req);
      chk($sformatf("tv%0d_mem_we", i), mem_we, tv[i].e_we);
      if (tv[i].e_req) chk($sformatf("tv%0d_mem_addr", i), mem_addr, tv[i].e_addr);
      chk($sformatf("tv%0d_if_valid", i), if_valid, tv[i].e_ifv);
      chk($sformatf("tv%0d_dm_valid", i), dm_valid, tv[i].e_dmv);
      chk($sformatf("tv%0d_stall_if", i), stall_if, tv[i].e_sif);
      chk($sformatf("tv%0d_stall_mem", i), stall_mem, tv[i].e_smem);
      if (tv[i].c_ird) chk($sformatf("tv%0d_if_rdata", i), if_rdata, tv[i].e_ird);
      if (tv[i].c_drd) chk($sformatf("tv%0d_dm_rdata", i), dm_rdata, tv[i].e_drd);
    end

    // Store with grant held off for 4 cycles
    do_reset();
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    w0 = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      cyc_drive(k == 4, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("st_req_c%0d", k), mem_req, 1);
      chk($sformatf("st_we_c%0d", k), mem_we, 1);
      chk($sformatf("st_addr_c%0d", k), mem_addr, 32'h20);
      chk($sformatf("st_wdata_c%0d", k), mem_wdata, 32'hDEADBEEF);
    end
    cyc_drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("st_rsp_wait_req", mem_req, 0);
    chk("st_rsp_wait_valid", dm_valid, 0);
    cyc_drive(1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk("st_rvalid_cycle_valid", dm_valid, 0);
    for (int k = 0; k < 3; k++) begin
      cyc_drive(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("st_hold_valid_c%0d", k), dm_valid, 1);
      chk($sformatf("st_hold_noreq_c%0d", k), mem_req, 0);
      chk($sformatf("st_hold_stall_c%0d", k), stall_mem, 0);
    end
    chk("st_write_count", wr_cnt - w0, 1);
    @(posedge clk); #1 adv = 1'b1;
    @(posedge clk); #1 adv = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    chk("st_adv_clears", dm_valid, 0);

    // Flush while the fetch response is outstanding
    do_reset();
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h40;
    cyc_drive(1'b1, 1'b0, 32'h0);
    cyc_drive(1'b0, 1'b0, 32'h0);
    if_flush = 1'b1; if_addr = 32'h44;
    cyc_drive(1'b0, 1'b1, 32'h0BAD0BAD);
    if_flush = 1'b0;
    cyc_drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("fl_dropped_valid", if_valid, 0);
    chk("fl_dropped_noreq", mem_req, 0);
    cyc_drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("fl_refetch_req", mem_req, 1);
    chk("fl_refetch_addr", mem_addr, 32'h44);
    cyc_drive(1'b0, 1'b1, 32'h44440000);
    cyc_drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("fl_new_valid", if_valid, 1);
    chk("fl_new_rdata", if_rdata, 32'h44440000);

    // Reset in the middle of a data request
    do_reset();
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104; if_req = 1'b1; if_addr = 32'h30;
    @(negedge clk);
    @(negedge clk);
    chk("rs_before_req", mem_req, 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("rs_async_req", mem_req, 0);
    chk("rs_async_addr", mem_addr, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rs_idle_req", mem_req, 0);
    @(negedge clk);
    chk("rs_reissue_req", mem_req, 1);
    chk("rs_reissue_addr", mem_addr, 32'h104);
    chk("rs_reissue_we", mem_we, 0);

    // Random traffic against the memory model
    do_reset();
    slave_auto = 1'b1;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
    for (int step = 0; step < 60; step++) begin
      pc = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      kind = $urandom_range(0, 2);
      dma = 32'h100 + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      wd = $urandom;
      flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
      w0 = wr_cnt;
      if_req = 1'b1; if_addr = pc;
      dm_req = (kind != 0); dm_we = (kind == 2); dm_addr = dma; dm_wdata = wd;
      p_pend = dm_req; p_dma = dma; p_dmw = dm_we;
      done = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        @(posedge clk); #1;
        if_flush = 1'b0;
        if (p_req && !mem_gnt) begin
          chk("rnd_req_hold", mem_req, 1);
          chk("rnd_addr_hold", mem_addr, p_addr);
          chk("rnd_we_hold", mem_we, p_we);
          chk("rnd_wdata_hold", mem_wdata, p_wd);
        end
        if (mem_req && !p_req && p_pend) begin
          chk("rnd_data_first_addr", mem_addr, p_dma);
          chk("rnd_data_first_we", mem_we, p_dmw);
        end
        if (if_valid && (!dm_req || dm_valid)) done = 1'b1;
        else if (cyc == flush_at) begin
          pc = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          if_addr = pc; if_flush = 1'b1;
        end
        p_req = mem_req; p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
        p_pend = dm_req && !dm_valid;
      end
      chk($sformatf("rnd%0d_completed", step), done, 1);
      chk($sformatf("rnd%0d_if_rdata", step), if_rdata, ref_rd(pc));
      if (kind == 1) begin
        chk($sformatf("rnd%0d_load_rdata", step), dm_rdata, ref_rd(dma));
        chk($sformatf("rnd%0d_load_no_write", step), wr_cnt - w0, 0);
      end else if (kind == 2) begin
        chk($sformatf("rnd%0d_store_once", step), wr_cnt - w0, 1);
        chk($sformatf("rnd%0d_store_addr", step), last_wa, dma);
        chk($sformatf("rnd%0d_store_data", step), last_wd, wd);
        ref_mem[dma] = wd;
      end else begin
        chk($sformatf("rnd%0d_fetch_no_write", step), wr_cnt - w0, 0);
      end
      adv = 1'b1;
      @(posedge clk); #1;
      adv = 1'b0;
      chk($sformatf("rnd%0d_adv_if_clear", step), if_valid, 0);
      chk($sformatf("rnd%0d_adv_dm_clear", step), dm_valid, 0);
      p_req = mem_req; p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
